clockrecv: RTL and testbench
============================

Name: clockrecv

Overview:
- Receiver end of the MCS-4 two-phase clock interface; sits inside peripheral and emulation logic clocked by sysclk.
- Brings externally driven clk1/clk2, which are asynchronous to sysclk, into the sysclk domain and produces single-cycle edge strobes.
- Checks pulse width and non-overlap of clk1/clk2.
- Tracks the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3), aligned by the SYNC signal.

Parameters:
- SYSCLK_TCY, 20, system clock period in ns.
- SYNC_STAGES, 2, synchronizer flop depth per input; minimum 2.
- MIN_TPW, 380, minimum legal clk1/clk2 high time in ns. MIN_TPW_CYC = MIN_TPW / SYSCLK_TCY (19 at defaults).

Ports:
- sysclk  input  1  system clock, sole clock.
- sysrst_n  input  1  asynchronous active-low reset.
- clk1_in  input  1  phase-1 clock, asynchronous.
- clk2_in  input  1  phase-2 clock, asynchronous.
- sync_in  input  1  SYNC, active-high during X3, asynchronous.
- err_clr  input  1  clears sticky error flags.
- clk1_rise  output  1  one-cycle strobe on synchronized clk1 rising edge.
- clk1_fall  output  1  one-cycle strobe on synchronized clk1 falling edge.
- clk2_rise  output  1  one-cycle strobe on synchronized clk2 rising edge.
- clk2_fall  output  1  one-cycle strobe on synchronized clk2 falling edge.
- phase  output  3  current phase: 0=A1 … 7=X3.
- locked  output  1  phase counter aligned to SYNC.
- err_width  output  1  sticky: a high pulse was shorter than MIN_TPW_CYC.
- err_overlap  output  1  sticky: clk1 and clk2 were high together.
- err_sync  output  1  sticky: SYNC was absent or misplaced.

Behaviour:
- Reset (async assert, sync release): all synchronizer flops, strobes, counters, phase, locked and error flags are 0. State is UNLOCKED.
- Synchronizers: clk1_in, clk2_in and sync_in each pass through SYNC_STAGES flops. Edge detection compares the last stage with one extra registered copy.
  - A strobe is asserted for exactly 1 cycle.
  - Latency is SYNC_STAGES+1 sysclk edges from the input transition (3 at default).
- Width counters, one per clock:
  - Cleared on the rising strobe.
  - Increment each cycle while the synchronized level is high; saturate at all-ones. Width is clog2 of the counter max, sized to hold 2*MIN_TPW_CYC.
  - On the falling strobe, if count < MIN_TPW_CYC, set err_width.
  - A pulse of exactly MIN_TPW_CYC cycles is legal.
- Overlap: set err_overlap in any cycle where both synchronized levels are high.
- SYNC capture: synchronized sync is sampled on the cycle clk2_fall is asserted and held in sync_seen until the next clk1_rise consumes it.
- Phase state machine. Phase advances on clk1_rise only.
  - UNLOCKED: phase holds 0. On clk1_rise with sync_seen=1, set phase=0, locked=1, go to LOCKED.
  - LOCKED: on each clk1_rise:
    - sync_seen=1 and phase==7: phase=0.
    - sync_seen=1 and phase!=7: set err_sync; phase=0 (realign); stay LOCKED.
    - sync_seen=0 and phase==7: set err_sync; locked=0; go to UNLOCKED; phase=0.
    - otherwise: phase=phase+1.
- Sticky errors: each flag clears on err_clr=1. If err_clr and a new error event occur in the same cycle, the flag ends set (set wins).
- Reset mid-operation: immediate return to the reset state. Strobes in flight are discarded, and the first edges after release are detected normally.
- Inputs idle low: no strobes, phase and locked hold.

Test Plan:
- Nominal drive at SYSCLK_TCY=20 (clk1 rises at 200ns, 400ns high; clk2 rises 400ns after clk1 falls, 400ns high; 1400ns period) -> clk1_rise appears 3 cycles after each clk1_in rise, one strobe per edge; no error flags set.
- Same drive with sync_in pulsed around the 8th clk2 fall -> locked=1 at the next clk1_rise with phase=0; phase then steps 0..7 and wraps to 0 at each correct SYNC; err_sync stays 0.
- Drop SYNC for one X3 after lock -> at the following clk1_rise: err_sync=1, locked=0, phase=0. Restoring SYNC relocks.
- Shorten one clk2 pulse to 360ns (18 cycles) -> err_width=1 after that clk2_fall. A 380ns pulse leaves err_width=0.
- Overlap clk1_in and clk2_in by 100ns -> err_overlap=1. Pulse err_clr in the same cycle as a fresh overlap -> err_overlap remains 1. Pulse err_clr later with no overlap -> 0.
- Assert sysrst_n=0 mid-phase while locked with errors set -> all outputs 0 immediately. After release, relock occurs on the next SYNC.

Source files
------------

// File: rtl/clockrecv.sv
// clockrecv: receiver for the MCS-4 two-phase clock (clk1/clk2) in the sysclk domain.
// Synchronizes clk1/clk2/SYNC, emits single-cycle edge strobes, checks pulse
// width and non-overlap, and tracks the 8-phase instruction cycle aligned by SYNC.
module clockrecv #(
    parameter int SYSCLK_TCY  = 20,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_TPW     = 380
) (
    input  logic       sysclk,
    input  logic       sysrst_n,
    input  logic       clk1_in,
    input  logic       clk2_in,
    input  logic       sync_in,
    input  logic       err_clr,
    output logic       clk1_rise,
    output logic       clk1_fall,
    output logic       clk2_rise,
    output logic       clk2_fall,
    output logic [2:0] phase,
    output logic       locked,
    output logic       err_width,
    output logic       err_overlap,
    output logic       err_sync
);

    localparam int MIN_TPW_CYC = MIN_TPW / SYSCLK_TCY;
    localparam int CNT_W       = $clog2(2 * MIN_TPW_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_TPW_CYC);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] clk1_sr, clk2_sr, sync_sr;
    logic                   clk1_dly, clk2_dly;
    logic                   clk1_lvl, clk2_lvl, sync_lvl;
    logic                   rise1_c, fall1_c, rise2_c, fall2_c;
    logic [CNT_W-1:0]       cnt1, cnt2;
    logic                   sync_seen;
    logic                   width_evt, overlap_evt, sync_evt;
    state_t                 state_q, state_d;
    logic [2:0]             phase_d;

    // Saturating increment: the counter parks at all-ones on very long pulses.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign clk1_lvl = clk1_sr[SYNC_STAGES-1];
    assign clk2_lvl = clk2_sr[SYNC_STAGES-1];
    assign sync_lvl = sync_sr[SYNC_STAGES-1];

    assign rise1_c = clk1_lvl & ~clk1_dly;
    assign fall1_c = ~clk1_lvl & clk1_dly;
    assign rise2_c = clk2_lvl & ~clk2_dly;
    assign fall2_c = ~clk2_lvl & clk2_dly;

    // A pulse is short if its high-cycle count at the falling edge is below the minimum.
    assign width_evt   = (fall1_c & (cnt1 < CNT_MIN)) | (fall2_c & (cnt2 < CNT_MIN));
    assign overlap_evt = clk1_lvl & clk2_lvl;
    assign locked      = (state_q == LOCKED);

    // Synchronizer chains, delayed copies for edge detection, and registered strobes.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            clk1_sr   <= '0;
            clk2_sr   <= '0;
            sync_sr   <= '0;
            clk1_dly  <= 1'b0;
            clk2_dly  <= 1'b0;
            clk1_rise <= 1'b0;
            clk1_fall <= 1'b0;
            clk2_rise <= 1'b0;
            clk2_fall <= 1'b0;
        end else begin
            clk1_sr   <= {clk1_sr[SYNC_STAGES-2:0], clk1_in};
            clk2_sr   <= {clk2_sr[SYNC_STAGES-2:0], clk2_in};
            sync_sr   <= {sync_sr[SYNC_STAGES-2:0], sync_in};
            clk1_dly  <= clk1_lvl;
            clk2_dly  <= clk2_lvl;
            clk1_rise <= rise1_c;
            clk1_fall <= fall1_c;
            clk2_rise <= rise2_c;
            clk2_fall <= fall2_c;
        end
    end

    // High-time counters; the rising cycle itself is the first high cycle counted.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (rise1_c)       cnt1 <= CNT_W'(1);
            else if (clk1_lvl) cnt1 <= sat_inc(cnt1);
            if (rise2_c)       cnt2 <= CNT_W'(1);
            else if (clk2_lvl) cnt2 <= sat_inc(cnt2);
        end
    end

    // SYNC is captured at the clk2 fall strobe and consumed by the next clk1 rise strobe.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n)      sync_seen <= 1'b0;
        else if (clk2_fall) sync_seen <= sync_lvl;
        else if (clk1_rise) sync_seen <= 1'b0;
    end

    // Phase state register.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q <= UNLOCKED;
            phase   <= 3'd0;
        end else begin
            state_q <= state_d;
            phase   <= phase_d;
        end
    end

    // Phase next-state: steps once per clk1 rise, realigns or drops lock on SYNC checks.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase;
        sync_evt = 1'b0;
        if (clk1_rise) begin
            case (state_q)
                UNLOCKED: begin
                    phase_d = 3'd0;
                    if (sync_seen) state_d = LOCKED;
                end
                LOCKED: begin
                    if (sync_seen) begin
                        sync_evt = (phase != 3'd7);
                        phase_d  = 3'd0;
                    end else if (phase == 3'd7) begin
                        sync_evt = 1'b1;
                        phase_d  = 3'd0;
                        state_d  = UNLOCKED;
                    end else begin
                        phase_d = phase + 3'd1;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    phase_d = 3'd0;
                end
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            err_width   <= 1'b0;
            err_overlap <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            err_width   <= (err_width   & ~err_clr) | width_evt;
            err_overlap <= (err_overlap & ~err_clr) | overlap_evt;
            err_sync    <= (err_sync    & ~err_clr) | sync_evt;
        end
    end

endmodule

// File: tb/tb_clockrecv.sv
// tb_clockrecv: randomized two-phase clock drive with a cycle-level reference model
// and a queue scoreboard checked by an independent negedge monitor.
module tb_clockrecv;

    localparam int MIN_CYC = 19;

    logic       sysclk = 1'b0;
    logic       sysrst_n = 1'b1;
    logic       clk1_in = 1'b0, clk2_in = 1'b0, sync_in = 1'b0, err_clr = 1'b0;
    logic       clk1_rise, clk1_fall, clk2_rise, clk2_fall;
    logic [2:0] phase;
    logic       locked, err_width, err_overlap, err_sync;

    clockrecv dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n),
        .clk1_in(clk1_in), .clk2_in(clk2_in), .sync_in(sync_in), .err_clr(err_clr),
        .clk1_rise(clk1_rise), .clk1_fall(clk1_fall),
        .clk2_rise(clk2_rise), .clk2_fall(clk2_fall),
        .phase(phase), .locked(locked),
        .err_width(err_width), .err_overlap(err_overlap), .err_sync(err_sync)
    );

    always #10 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int ph;
        int lk;
        int es;
    } exp_t;

    int   qcyc[4][$];   // expected strobe cycles: 0=clk1_rise 1=clk1_fall 2=clk2_rise 3=clk2_fall
    exp_t qph[$];       // expected phase/locked/err_sync after each clk1 rise
    int   qew[$];       // expected err_width after each clk2 fall

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit force_lock = 1'b0;

    // reference model state
    int m_phase = 0;
    int m_locked = 0;
    int m_sync = 0;
    int m_errs = 0;
    int m_errw = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #5;
    endtask

    task automatic pop_cyc(input int idx, input string nm);
        int e;
        if (qcyc[idx].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected strobe at cycle %0d", nm, cyc);
        end else begin
            e = qcyc[idx].pop_front();
            check(nm, cyc, e);
        end
    endtask

    // Model of one clk1 rise: phase advance, SYNC alignment and lock tracking.
    task automatic model_rise();
        exp_t e;
        if (m_locked == 0) begin
            m_phase = 0;
            if (m_sync != 0) m_locked = 1;
        end else if (m_sync != 0) begin
            if (m_phase != 7) m_errs = 1;
            m_phase = 0;
        end else if (m_phase == 7) begin
            m_errs = 1;
            m_locked = 0;
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % 8;
        end
        m_sync = 0;
        e.ph = m_phase;
        e.lk = m_locked;
        e.es = m_errs;
        qph.push_back(e);
    endtask

    // One full two-phase period: clk1 high w1 cycles, 20 low, clk2 high w2 cycles, then gap.
    task automatic period(input int w1, input int w2);
        bit s;
        bit clr;
        clk1_in = 1'b1;
        qcyc[0].push_back(cyc + 3);
        model_rise();
        tick(w1);
        clk1_in = 1'b0;
        qcyc[1].push_back(cyc + 3);
        if (force_lock)          s = (m_locked == 0) || (m_phase == 7);
        else if (m_locked == 0)  s = ($urandom_range(0, 1) == 1);
        else if (m_phase == 7)   s = ($urandom_range(0, 7) != 0);
        else                     s = ($urandom_range(0, 9) == 0);
        tick(20);
        clk2_in = 1'b1;
        qcyc[2].push_back(cyc + 3);
        tick(5);
        sync_in = s;
        tick(w2 - 5);
        clk2_in = 1'b0;
        qcyc[3].push_back(cyc + 3);
        if (w2 < MIN_CYC) m_errw = 1;
        qew.push_back(m_errw);
        m_sync = s;
        tick(5);
        sync_in = 1'b0;
        tick(15);
        clr = (!force_lock) && ($urandom_range(0, 5) == 0);
        if (clr) begin
            err_clr = 1'b1;
            m_errw = 0;
            m_errs = 0;
            tick(1);
            err_clr = 1'b0;
        end
        tick(5);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " clk1_rise"}, clk1_rise, 0);
        check({tag, " clk1_fall"}, clk1_fall, 0);
        check({tag, " clk2_rise"}, clk2_rise, 0);
        check({tag, " clk2_fall"}, clk2_fall, 0);
        check({tag, " phase"}, phase, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " err_width"}, err_width, 0);
        check({tag, " err_overlap"}, err_overlap, 0);
        check({tag, " err_sync"}, err_sync, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " clk1_rise pending"}, qcyc[0].size(), 0);
        check({tag, " clk1_fall pending"}, qcyc[1].size(), 0);
        check({tag, " clk2_rise pending"}, qcyc[2].size(), 0);
        check({tag, " clk2_fall pending"}, qcyc[3].size(), 0);
        check({tag, " phase pending"}, qph.size(), 0);
    endtask

    // Monitor: compares strobes and status against the scoreboard, away from the active edge.
    bit pend = 1'b0;
    always @(negedge sysclk) begin
        if (!mon_en) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (qph.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL phase: no expectation at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = qph.pop_front();
                    check("phase", phase, e.ph);
                    check("locked", locked, e.lk);
                    check("err_sync", err_sync, e.es);
                    check("err_overlap", err_overlap, 0);
                end
            end
            if (clk1_rise) begin
                pop_cyc(0, "clk1_rise");
                pend = 1'b1;
            end
            if (clk1_fall) pop_cyc(1, "clk1_fall");
            if (clk2_rise) pop_cyc(2, "clk2_rise");
            if (clk2_fall) begin
                pop_cyc(3, "clk2_fall");
                if (qew.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL err_width: no expectation at cycle %0d", cyc);
                end else begin
                    check("err_width", err_width, qew.pop_front());
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w1, w2;
        #1 sysrst_n = 1'b0;
        tick(3);
        check_all_zero("reset");
        sysrst_n = 1'b1;
        tick(5);
        mon_en = 1'b1;

        for (int i = 0; i < 50; i++) begin
            w1 = (i == 0) ? 19 : int'($urandom_range(19, 22));
            if (i == 0)      w2 = 19;
            else if (i == 3) w2 = 18;
            else             w2 = int'($urandom_range(17, 21));
            period(w1, w2);
        end

        force_lock = 1'b1;
        for (int i = 0; i < 10; i++) period(20, 20);
        tick(10);
        check("locked after relock run", locked, m_locked);
        check("phase after relock run", phase, m_phase);
        check_drained("random");
        mon_en = 1'b0;

        // overlap of 5 cycles (100ns) inside a clk1 pulse
        clk1_in = 1'b1;
        tick(10);
        clk2_in = 1'b1;
        tick(5);
        clk2_in = 1'b0;
        tick(10);
        clk1_in = 1'b0;
        tick(10);
        check("err_overlap set", err_overlap, 1);

        // clear while overlap is still occurring: set wins
        clk1_in = 1'b1;
        clk2_in = 1'b1;
        tick(10);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        check("err_overlap clr vs new", err_overlap, 1);
        clk1_in = 1'b0;
        clk2_in = 1'b0;
        tick(10);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(2);
        check("err_overlap cleared", err_overlap, 0);

        // reset mid-pulse with a strobe in flight
        clk2_in = 1'b1;
        tick(4);
        clk2_in = 1'b0;
        clk1_in = 1'b1;
        tick(2);
        sysrst_n = 1'b0;
        #1;
        check_all_zero("mid-op reset");
        tick(3);
        for (int k = 0; k < 4; k++) qcyc[k].delete();
        qph.delete();
        qew.delete();
        m_phase = 0; m_locked = 0; m_sync = 0; m_errs = 0; m_errw = 0;
        sysrst_n = 1'b1;
        mon_en = 1'b1;
        qcyc[0].push_back(cyc + 3);
        model_rise();
        tick(25);
        clk1_in = 1'b0;
        qcyc[1].push_back(cyc + 3);
        tick(30);

        for (int i = 0; i < 10; i++) period(20, 20);
        tick(10);
        check("locked after reset relock", locked, 1);
        check("phase after reset relock", phase, m_phase);
        check("err_width after reset", err_width, 0);
        check_drained("post-reset");
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
